// File: rtl/pueo_thresh_pkg.sv
// Shared types for the dual-threshold chain loader: word width, select encodings,
// FSM state enum and the chain stage -> shadow address mapping.
package pueo_thresh_pkg;

  localparam int THR_W = 18;

  localparam logic SEL_MAIN  = 1'b0;
  localparam logic SEL_DELTA = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UPDATE,
    S_SETTLE
  } state_t;

  // Shadow address {channel, sel} of the word that must land in chain stage `stage` on `lane`.
  // Even stages are a block's main threshold (stage A), odd stages its delta (stage B).
  function automatic int unsigned stage_addr(input int unsigned stage, input int unsigned lane);
    int unsigned ch;
    int unsigned sel;
    ch  = (stage >> 1) * 2 + lane;
    sel = (stage % 2 == 1) ? 32'(SEL_DELTA) : 32'(SEL_MAIN);
    return ch * 2 + sel;
  endfunction

endpackage

// File: rtl/thresh_chain_loader_if.sv
// Host + chain-side signal bundle for thresh_chain_loader.
// Optional readback port appears when THRESH_LOADER_READBACK_EN is defined.
interface thresh_chain_loader_if
  import pueo_thresh_pkg::*;
#(
  parameter int NBLK = 4
) ();

  localparam int AW = $clog2(2 * NBLK) + 1;

  // Handshake: thr_wr and apply are single-cycle strobes with no ready; both are always
  // accepted (apply while busy is remembered as one pending request). done is a 1-cycle
  // pulse, thresh is valid exactly while thresh_wr is high.
  logic [AW-1:0]        thr_addr;
  logic [THR_W-1:0]     thr_dat;
  logic                 thr_wr;
  logic                 apply;
  logic                 busy;
  logic                 done;
  logic [2*THR_W-1:0]   thresh;
  logic [1:0]           thresh_wr;
  logic [1:0]           thresh_update;
  state_t               dbg_state;
`ifdef THRESH_LOADER_READBACK_EN
  logic [AW-1:0]        rd_addr;
  logic [THR_W-1:0]     rd_dat;

  modport slave (
    input  thr_addr, thr_dat, thr_wr, apply, rd_addr,
    output busy, done, thresh, thresh_wr, thresh_update, dbg_state, rd_dat
  );
  modport master (
    output thr_addr, thr_dat, thr_wr, apply, rd_addr,
    input  busy, done, thresh, thresh_wr, thresh_update, dbg_state, rd_dat
  );
`else
  modport slave (
    input  thr_addr, thr_dat, thr_wr, apply,
    output busy, done, thresh, thresh_wr, thresh_update, dbg_state
  );
  modport master (
    output thr_addr, thr_dat, thr_wr, apply,
    input  busy, done, thresh, thresh_wr, thresh_update, dbg_state
  );
`endif

endinterface

// File: rtl/thresh_shadow_rf.sv
// Shadow register file: one write port, two combinational sequencer read ports and,
// with THRESH_LOADER_READBACK_EN, a registered host readback port.
module thresh_shadow_rf
  import pueo_thresh_pkg::*;
#(
  parameter int               NBLK      = 4,
  parameter logic [THR_W-1:0] RST_MAIN  = 18'h0FFFF,
  parameter logic [THR_W-1:0] RST_DELTA = 18'h00100,
  localparam int              AW        = $clog2(2 * NBLK) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [THR_W-1:0] wr_dat_i,
  input  logic [AW-1:0]    rd0_addr_i,
  input  logic [AW-1:0]    rd1_addr_i,
  output logic [THR_W-1:0] rd0_dat_o,
  output logic [THR_W-1:0] rd1_dat_o
`ifdef THRESH_LOADER_READBACK_EN
  ,
  input  logic [AW-1:0]    rb_addr_i,
  output logic [THR_W-1:0] rb_dat_o
`endif
);

  localparam int NENT = 4 * NBLK;

  logic [THR_W-1:0] mem_q [NENT];

  function automatic logic [THR_W-1:0] rd_word(input logic [AW-1:0] a);
    return (int'(a) < NENT) ? mem_q[a] : '0;
  endfunction

  // Odd addresses hold deltas; out-of-range channels are silently dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NENT; i++) begin
        mem_q[i] <= (i % 2 == 1) ? RST_DELTA : RST_MAIN;
      end
    end else if (wr_i && (int'(wr_addr_i) < NENT)) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd0_dat_o = rd_word(rd0_addr_i);
  assign rd1_dat_o = rd_word(rd1_addr_i);

`ifdef THRESH_LOADER_READBACK_EN
  logic [THR_W-1:0] rb_dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rb_dat_q <= '0;
    else       rb_dat_q <= rd_word(rb_addr_i);
  end

  assign rb_dat_o = rb_dat_q;
`endif

endmodule

// File: rtl/thresh_chain_loader.sv
// Writer end of the cascaded dual-threshold chain: shifts the shadow copy into the chain,
// then fires one update. THRESH_LOADER_READBACK_EN enables the shadow readback port.
module thresh_chain_loader
  import pueo_thresh_pkg::*;
#(
  parameter int               NBLK       = 4,
  parameter logic [THR_W-1:0] RST_MAIN   = 18'h0FFFF,
  parameter logic [THR_W-1:0] RST_DELTA  = 18'h00100,
  parameter bit               INIT_LOAD  = 1'b1,
  parameter int               SETTLE_CYC = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  thresh_chain_loader_if.slave bus
);

  localparam int NSTG = 2 * NBLK;
  localparam int SW   = $clog2(NSTG);
  localparam int AW   = SW + 1;
  localparam int CW   = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] LAST_STEP   = SW'(NSTG - 1);
  localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYC - 1);

  state_t             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [CW-1:0]      settle_q, settle_d;
  logic               pending_q, pending_d;
  logic               init_q, init_d;
  logic               done_q, done_d;
  logic [2*THR_W-1:0] thresh_q, thresh_d;
  logic [SW-1:0]      stage_d;
  logic [AW-1:0]      rd0_addr, rd1_addr;
  logic [THR_W-1:0]   rd0_dat, rd1_dat;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    settle_d  = settle_q;
    pending_d = pending_q;
    init_d    = init_q;
    done_d    = 1'b0;
    if (bus.apply && (state_q != S_IDLE)) pending_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.apply || pending_q || init_q) begin
          state_d   = S_LOAD;
          step_d    = '0;
          pending_d = 1'b0;
          init_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (step_q == LAST_STEP) state_d = S_UPDATE;
        else                     step_d  = step_q + 1'b1;
      end
      S_UPDATE: begin
        state_d  = S_SETTLE;
        settle_d = '0;
      end
      S_SETTLE: begin
        if (settle_q == LAST_SETTLE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch the word for the step about to be presented so thresh_q lines up with thresh_wr.
  always_comb begin
    stage_d  = LAST_STEP - step_d;
    rd0_addr = AW'(stage_addr(32'(stage_d), 0));
    rd1_addr = AW'(stage_addr(32'(stage_d), 1));
    thresh_d = (state_d == S_LOAD) ? {rd1_dat, rd0_dat} : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      settle_q  <= '0;
      pending_q <= 1'b0;
      init_q    <= INIT_LOAD;
      done_q    <= 1'b0;
      thresh_q  <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      settle_q  <= settle_d;
      pending_q <= pending_d;
      init_q    <= init_d;
      done_q    <= done_d;
      thresh_q  <= thresh_d;
    end
  end

  thresh_shadow_rf #(
    .NBLK      (NBLK),
    .RST_MAIN  (RST_MAIN),
    .RST_DELTA (RST_DELTA)
  ) u_shadow (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_i       (bus.thr_wr),
    .wr_addr_i  (bus.thr_addr),
    .wr_dat_i   (bus.thr_dat),
    .rd0_addr_i (rd0_addr),
    .rd1_addr_i (rd1_addr),
    .rd0_dat_o  (rd0_dat),
    .rd1_dat_o  (rd1_dat)
`ifdef THRESH_LOADER_READBACK_EN
    ,
    .rb_addr_i  (bus.rd_addr),
    .rb_dat_o   (bus.rd_dat)
`endif
  );

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = done_q;
  assign bus.thresh        = thresh_q;
  assign bus.thresh_wr     = {2{state_q == S_LOAD}};
  assign bus.thresh_update = {2{state_q == S_UPDATE}};
  assign bus.dbg_state     = state_q;

endmodule
